pipelined_prefix_addsub: RTL and testbench

Parametrised, pipelined Kogge-Stone prefix adder/subtractor with carry-in, carry-out and signed overflow. It is the successor to the fixed 32-bit pipelined prefix adder. It adds configurable width and latency, an add/sub mode, and valid/ready flow control with backpressure. It sits between operand-producing datapath stages and result consumers that may stall.

---
 rtl/pipelined_prefix_addsub.sv | 154 +++++++++++++++
 tb/tb_pipelined_prefix_addsub.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_addsub.sv
// Kogge-Stone adder/subtractor with carry-in, carry-out, signed overflow and a sideband tag.
// Latency: LATENCY register stages from acceptance to out_valid, spread evenly over the prefix levels.
// Backpressure: each stage loads when empty or when its successor loads, so bubbles collapse; in_ready is combinational.
module pipelined_prefix_addsub #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LVLS = $clog2(WIDTH);

    // g: group generate so far (carry-in folded into bit 0), p: group propagate,
    // x: original bitwise propagate kept for the final sum.
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] x;
        logic             cin;
        logic [TAG_W-1:0] tag;
    } node_t;

    // Steps are 0 (G/P formation) and 1..LVLS (prefix levels); segment k ends after step seg_end(k).
    function automatic int seg_end(input int k);
        return ((k + 1) * (LVLS + 1)) / LATENCY - 1;
    endfunction

    function automatic bit is_reg(input int s);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < LATENCY - 1; k++)
            if (seg_end(k) == s) hit = 1'b1;
        return hit;
    endfunction

    function automatic int stage_of(input int s);
        int idx;
        idx = 0;
        for (int k = 0; k < LATENCY - 1; k++)
            if (seg_end(k) == s) idx = k;
        return idx;
    endfunction

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] ld;
    logic [LATENCY:0]   src_vld;

    assign src_vld   = {vld, in_valid};
    assign in_ready  = ld[0];
    assign out_valid = vld[LATENCY-1];

    // A stage may load if any stage at or beyond it has room, or the consumer takes the result.
    always_comb begin : load_chain
        logic room;
        room = out_ready;
        ld   = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            room  = room | ~vld[k];
            ld[k] = room;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++)
                if (ld[k]) vld[k] <= src_vld[k];
        end
    end

    for (genvar s = 0; s <= LVLS; s++) begin : g_step
        node_t comb;
        node_t bnd;

        if (s == 0) begin : g_gp
            logic [WIDTH-1:0] eff_b;
            logic             eff_cin;

            assign eff_b   = in_sub ? ~in_b : in_b;
            assign eff_cin = in_sub | in_cin;

            always_comb begin
                comb.x    = in_a ^ eff_b;
                comb.p    = in_a ^ eff_b;
                comb.g    = in_a & eff_b;
                comb.g[0] = (in_a[0] & eff_b[0]) | ((in_a[0] ^ eff_b[0]) & eff_cin);
                comb.cin  = eff_cin;
                comb.tag  = in_tag;
            end
        end else begin : g_lvl
            localparam int D = 1 << (s - 1);
            node_t din;

            assign din = g_step[s-1].bnd;

            always_comb begin
                comb = din;
                for (int i = D; i < WIDTH; i++) begin
                    comb.g[i] = din.g[i] | (din.p[i] & din.g[i-D]);
                    comb.p[i] = din.p[i] & din.p[i-D];
                end
            end
        end

        if (is_reg(s)) begin : g_reg
            localparam int K = stage_of(s);
            always_ff @(posedge clk) begin
                if (ld[K]) bnd <= comb;
            end
        end else begin : g_pass
            assign bnd = comb;
        end
    end

    node_t            fin;
    logic [WIDTH-1:0] carries;
    logic             unused_p;

    assign fin      = g_step[LVLS].bnd;
    assign carries  = {fin.g[WIDTH-2:0], fin.cin};
    assign unused_p = ^fin.p;

    // Output registers are reset so a freshly reset block presents zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_tag  <= '0;
        end else if (ld[LATENCY-1]) begin
            out_sum  <= fin.x ^ carries;
            out_cout <= fin.g[WIDTH-1];
            out_ovf  <= fin.g[WIDTH-1] ^ fin.g[WIDTH-2];
            out_tag  <= fin.tag;
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
// Directed bench for pipelined_prefix_addsub: 32-bit/latency-3 main instance plus
// 4-bit/latency-1 (exhaustive) and 16-bit/latency-5 (random stream) instances.
module tb_pipelined_prefix_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
    logic [31:0] in_a, in_b, out_sum;
    logic [3:0]  in_tag, out_tag;

    logic        s_in_valid, s_in_ready, s_in_cin, s_in_sub, s_out_valid, s_out_ready, s_out_cout, s_out_ovf;
    logic [3:0]  s_in_a, s_in_b, s_out_sum, s_in_tag, s_out_tag;

    logic        m_in_valid, m_in_ready, m_in_cin, m_in_sub, m_out_valid, m_out_ready, m_out_cout, m_out_ovf;
    logic [15:0] m_in_a, m_in_b, m_out_sum;
    logic [7:0]  m_in_tag, m_out_tag;

    int checks = 0;
    int errors = 0;

    pipelined_prefix_addsub #(.WIDTH(32), .LATENCY(3), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag));

    pipelined_prefix_addsub #(.WIDTH(4), .LATENCY(1), .TAG_W(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
        .in_cin(s_in_cin), .in_sub(s_in_sub), .in_tag(s_in_tag), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf), .out_tag(s_out_tag));

    pipelined_prefix_addsub #(.WIDTH(16), .LATENCY(5), .TAG_W(8)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_a(m_in_a), .in_b(m_in_b),
        .in_cin(m_in_cin), .in_sub(m_in_sub), .in_tag(m_in_tag), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_sum(m_out_sum), .out_cout(m_out_cout), .out_ovf(m_out_ovf), .out_tag(m_out_tag));

    // Issue one op into an idle main pipeline and wait for its result; lat=99 on timeout.
    task automatic send_wait(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                             input logic [3:0] tag, output logic [31:0] s, output logic co, output logic ov,
                             output logic [3:0] t, output int lat);
        out_ready = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
        s = out_sum; co = out_cout; ov = out_ovf; t = out_tag;
    endtask

    function automatic logic [31:0] bp_a(input int t);
        logic [31:0] tt;
        tt = t;
        return tt * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] bp_sum(input int t);
        logic [31:0] tt;
        tt = t;
        return bp_a(t) + 32'h0000_0F00 + tt + {31'b0, tt[0]};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum got %h want 0", out_sum); end
        checks++; if ({out_cout, out_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {out_cout, out_ovf}); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if ({s_out_valid, m_out_valid} !== 2'b00) begin errors++; $display("FAIL reset_side_valid got %b want 00", {s_out_valid, m_out_valid}); end
    endtask

    task automatic test_add;
        logic [31:0] s; logic co, ov; logic [3:0] t; int lat;
        send_wait(32'd1, 32'd1, 1'b0, 1'b0, 4'h5, s, co, ov, t, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
        checks++; if ({s, co, ov} !== {32'h0000_0002, 2'b00}) begin errors++; $display("FAIL add_1p1 got %h/%b%b want 00000002/00", s, co, ov); end
        checks++; if (t !== 4'h5) begin errors++; $display("FAIL add_tag got %h want 5", t); end
        send_wait(32'd5, 32'd3, 1'b1, 1'b0, 4'h6, s, co, ov, t, lat);
        checks++; if ({s, co, ov} !== {32'h0000_0009, 2'b00}) begin errors++; $display("FAIL add_cin got %h/%b%b want 00000009/00", s, co, ov); end
        send_wait(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'h7, s, co, ov, t, lat);
        checks++; if ({s, co, ov} !== {32'h0000_0000, 2'b10}) begin errors++; $display("FAIL add_cin_wrap got %h/%b%b want 00000000/10", s, co, ov); end
    endtask

    task automatic test_carry_ovf;
        logic [31:0] s; logic co, ov; logic [3:0] t; int lat;
        send_wait(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h1, s, co, ov, t, lat);
        checks++; if ({s, co, ov} !== {32'h0000_0000, 2'b10}) begin errors++; $display("FAIL carry_out got %h/%b%b want 00000000/10", s, co, ov); end
        send_wait(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h2, s, co, ov, t, lat);
        checks++; if ({s, co, ov} !== {32'h8000_0000, 2'b01}) begin errors++; $display("FAIL pos_ovf got %h/%b%b want 80000000/01", s, co, ov); end
    endtask

    task automatic test_sub;
        logic [31:0] s; logic co, ov; logic [3:0] t; int lat;
        send_wait(32'd7, 32'd5, 1'b1, 1'b1, 4'h3, s, co, ov, t, lat);
        checks++; if ({s, co, ov} !== {32'h0000_0002, 2'b10}) begin errors++; $display("FAIL sub_7m5 got %h/%b%b want 00000002/10", s, co, ov); end
        send_wait(32'd5, 32'd7, 1'b0, 1'b1, 4'h4, s, co, ov, t, lat);
        checks++; if ({s, co, ov} !== {32'hFFFF_FFFE, 2'b00}) begin errors++; $display("FAIL sub_5m7 got %h/%b%b want FFFFFFFE/00", s, co, ov); end
        send_wait(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'h8, s, co, ov, t, lat);
        checks++; if ({s, co, ov} !== {32'h7FFF_FFFF, 2'b11}) begin errors++; $display("FAIL sub_neg_ovf got %h/%b%b want 7FFFFFFF/11", s, co, ov); end
    endtask

    task automatic test_backpressure;
        int sent = 0, recv = 0, first_c = -1, last_c = -1, hold_bad = 0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 10);
            in_valid = (sent < 8);
            in_a = bp_a(sent); in_b = 32'h0000_0F00 + sent; in_cin = sent[0]; in_sub = 1'b0; in_tag = sent[3:0];
            #1;
            if (c == 9) begin
                checks++; if (sent != 3) begin errors++; $display("FAIL bp_accept_count got %0d want 3", sent); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
                checks++; if ({out_valid, out_tag} !== 5'b1_0000) begin errors++; $display("FAIL bp_held_head got %b/%h want 1/0", out_valid, out_tag); end
                checks++; if (out_sum !== bp_sum(0)) begin errors++; $display("FAIL bp_held_sum got %h want %h", out_sum, bp_sum(0)); end
            end
            if (c < 10 && out_valid && (out_tag !== 4'h0 || out_sum !== bp_sum(0))) hold_bad++;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++;
                if (out_tag !== recv[3:0] || out_sum !== bp_sum(recv)) begin
                    errors++; $display("FAIL bp_order got tag %h sum %h want tag %h sum %h", out_tag, out_sum, recv[3:0], bp_sum(recv));
                end
                if (recv == 0) first_c = c;
                last_c = c;
                recv++;
            end
        end
        in_valid = 1'b0;
        checks++; if (recv != 8) begin errors++; $display("FAIL bp_recv_count got %0d want 8", recv); end
        checks++; if (last_c - first_c != 7) begin errors++; $display("FAIL bp_drain_rate got span %0d want 7", last_c - first_c); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold_stable got %0d changes want 0", hold_bad); end
    endtask

    task automatic test_back_to_back;
        int recv = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && recv < 4; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 4);
            in_a = 32'h1000_0000 * c; in_b = 32'h0000_00FF; in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'hA + c[3:0];
            #1;
            if (out_valid) begin
                checks++;
                if (c != 3 + recv || out_tag !== 4'hA + recv[3:0] || out_sum !== 32'h1000_0000 * recv + 32'hFF) begin
                    errors++; $display("FAIL b2b_result cycle %0d got tag %h sum %h want cycle %0d tag %h", c, out_tag, out_sum, 3 + recv, 4'hA + recv[3:0]);
                end
                recv++;
            end
        end
        in_valid = 1'b0;
        checks++; if (recv != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", recv); end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] s; logic co, ov; logic [3:0] t; int lat; int stray = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 32'h100 * (i + 1); in_b = 32'h1; in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'h9 + i[3:0];
        end
        @(posedge clk); #1;
        rst = 1'b1; in_tag = 4'hC; in_a = 32'hDEAD_0000;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL mid_reset_sum got %h want 0", out_sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_reset_stray got %0d results want 0", stray); end
        send_wait(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'hE, s, co, ov, t, lat);
        checks++; if ({s, t} !== {32'h2345_6789, 4'hE}) begin errors++; $display("FAIL mid_reset_recover got %h/%h want 23456789/E", s, t); end
    endtask

    task automatic test_w4_exhaustive;
        logic [9:0] q[$];
        logic [9:0] e;
        logic [10:0] idx = 0;
        logic [3:0] eb, low;
        logic [4:0] full;
        int recv = 0, lat = 1;
        // Full-rate latency on an idle pipeline: 2 + 3 = 5 with no carry.
        s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_a = 4'd2; s_in_b = 4'd3; s_in_cin = 1'b0; s_in_sub = 1'b0; s_in_tag = 4'h1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        while (!s_out_valid && lat < 8) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 1 || s_out_sum !== 4'd5) begin errors++; $display("FAIL w4_latency got %0d/%h want 1/5", lat, s_out_sum); end
        for (int c = 0; c < 8000 && recv < 1024; c++) begin
            @(posedge clk); #1;
            s_out_ready = ($urandom_range(0, 3) != 0);
            s_in_valid  = (idx < 1024) && ($urandom_range(0, 3) != 0);
            {s_in_sub, s_in_cin, s_in_a, s_in_b} = idx[9:0];
            s_in_tag = idx[3:0];
            #1;
            if (s_in_valid && s_in_ready) begin
                eb   = s_in_sub ? ~s_in_b : s_in_b;
                full = {1'b0, s_in_a} + {1'b0, eb} + {4'b0, s_in_sub | s_in_cin};
                low  = {1'b0, s_in_a[2:0]} + {1'b0, eb[2:0]} + {3'b0, s_in_sub | s_in_cin};
                q.push_back({low[3] ^ full[4], full[4], full[3:0], s_in_tag});
                idx++;
            end
            if (s_out_valid && s_out_ready) begin
                checks++;
                e = (q.size() != 0) ? q.pop_front() : 10'h3FF;
                if ({s_out_ovf, s_out_cout, s_out_sum, s_out_tag} !== e) begin
                    errors++; $display("FAIL w4_result got %b want %b", {s_out_ovf, s_out_cout, s_out_sum, s_out_tag}, e);
                end
                recv++;
            end
        end
        s_in_valid = 1'b0;
        checks++; if (recv != 1024 || q.size() != 0) begin errors++; $display("FAIL w4_count got %0d left %0d want 1024 left 0", recv, q.size()); end
    endtask

    task automatic test_w16_stream;
        logic [25:0] q[$];
        logic [25:0] e;
        logic [15:0] eb, low;
        logic [16:0] full;
        logic [7:0] tag = 0;
        int sent = 0, recv = 0, lat = 1;
        m_out_ready = 1'b1; m_in_valid = 1'b1; m_in_a = 16'hFFFF; m_in_b = 16'h0001; m_in_cin = 1'b0; m_in_sub = 1'b0; m_in_tag = 8'h5A;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        while (!m_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 5) begin errors++; $display("FAIL w16_latency got %0d want 5", lat); end
        checks++; if ({m_out_sum, m_out_cout, m_out_tag} !== {16'h0000, 1'b1, 8'h5A}) begin
            errors++; $display("FAIL w16_wrap got %h/%b/%h want 0000/1/5A", m_out_sum, m_out_cout, m_out_tag);
        end
        for (int c = 0; c < 12000 && recv < 2000; c++) begin
            @(posedge clk); #1;
            m_out_ready = ($urandom_range(0, 2) != 0);
            m_in_valid  = (sent < 2000) && ($urandom_range(0, 2) != 0);
            m_in_a = 16'($urandom); m_in_b = 16'($urandom);
            m_in_cin = 1'($urandom); m_in_sub = 1'($urandom); m_in_tag = tag;
            #1;
            if (m_in_valid && m_in_ready) begin
                eb   = m_in_sub ? ~m_in_b : m_in_b;
                full = {1'b0, m_in_a} + {1'b0, eb} + {16'b0, m_in_sub | m_in_cin};
                low  = {1'b0, m_in_a[14:0]} + {1'b0, eb[14:0]} + {15'b0, m_in_sub | m_in_cin};
                q.push_back({low[15] ^ full[16], full[16], full[15:0], m_in_tag});
                sent++; tag++;
            end
            if (m_out_valid && m_out_ready) begin
                checks++;
                e = (q.size() != 0) ? q.pop_front() : 26'h3FF_FFFF;
                if ({m_out_ovf, m_out_cout, m_out_sum, m_out_tag} !== e) begin
                    errors++; $display("FAIL w16_result got %h want %h", {m_out_ovf, m_out_cout, m_out_sum, m_out_tag}, e);
                end
                recv++;
            end
        end
        m_in_valid = 1'b0;
        checks++; if (recv != 2000 || q.size() != 0) begin errors++; $display("FAIL w16_count got %0d left %0d want 2000 left 0", recv, q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_in_sub = 1'b0; s_in_tag = '0; s_out_ready = 1'b1;
        m_in_valid = 1'b0; m_in_a = '0; m_in_b = '0; m_in_cin = 1'b0; m_in_sub = 1'b0; m_in_tag = '0; m_out_ready = 1'b1;
        test_reset();
        test_add();
        test_carry_ovf();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_w4_exhaustive();
        test_w16_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
